// File: rtl/hall_call_pkg.sv
// Shared constants and helpers for the hall-call request stage.
package hall_call_pkg;

  localparam int FLOORS = 5;
  localparam int POS_W  = 3;

  // One-hot floor mask for a car position; positions past the top floor map to zero.
  function automatic logic [FLOORS-1:0] floor_onehot(input logic [POS_W-1:0] pos);
    logic [FLOORS-1:0] mask;
    mask = '0;
    for (int f = 0; f < FLOORS; f++) begin
      if (pos == POS_W'(f)) mask[f] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/hall_call_latch_btn_debounce.sv
// Single-button front end: 2-FF synchroniser, optional debounce counter
// (HALL_CALL_DEBOUNCE_EN), and a one-cycle press pulse on the clean rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  logic sync1;
  logic sync2;
  logic stable;
  logic prev_stable;

`ifdef HALL_CALL_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      prev_stable <= 1'b0;
      cnt         <= '0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      prev_stable <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  // No counter in this build; the parameters only shape the configuration check.
  if (DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_unused_cfg
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      prev_stable <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      stable      <= sync2;
      prev_stable <= stable;
    end
  end
`endif

  // Only the rising edge of the clean level is a press; releases are ignored.
  assign press = stable & ~prev_stable;

endmodule

// File: rtl/hall_call_latch.sv
// Hall-call request stage: per-floor debounced buttons feed a pending lamp mask and
// one-cycle floor_req pulses. Debounce counters exist only with HALL_CALL_DEBOUNCE_EN.
module hall_call_latch #(
  parameter int FLOORS          = hall_call_pkg::FLOORS,
  parameter int POS_W           = hall_call_pkg::POS_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn_raw,
  input  logic [POS_W-1:0]  floor_pos,
  input  logic              door_open,
  output logic [FLOORS-1:0] floor_req,
  output logic [FLOORS-1:0] pending
);

  import hall_call_pkg::*;

  logic [FLOORS-1:0] press;
  logic [FLOORS-1:0] serve;

  for (genvar f = 0; f < FLOORS; f++) begin : g_floor
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[f]),
      .press  (press[f])
    );
  end

  assign serve = door_open ? floor_onehot(floor_pos) : '0;

  // Service beats a same-cycle press; a press on an already-lit floor is swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      floor_req <= '0;
    end else begin
      floor_req <= press & ~pending & ~serve;
      pending   <= (pending | press) & ~serve;
    end
  end

endmodule

// File: tb/tb_hall_call_latch.sv
// Directed scenarios plus randomized traffic for hall_call_latch, checked every cycle
// against a sample-window reference model.
module tb_hall_call_latch;

  localparam int FLOORS = 5;
`ifdef HALL_CALL_DEBOUNCE_EN
  localparam int EFF_D = 4;
`else
  localparam int EFF_D = 1;
`endif

  logic              clk;
  logic              reset;
  logic [FLOORS-1:0] btn_raw;
  logic [2:0]        floor_pos;
  logic              door_open;
  logic [FLOORS-1:0] floor_req;
  logic [FLOORS-1:0] pending;

  int checks;
  int errors;

  hall_call_latch #(
    .FLOORS(5), .POS_W(3), .DEBOUNCE_CYCLES(4), .CNT_W(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .floor_pos(floor_pos),
    .door_open(door_open),
    .floor_req(floor_req),
    .pending  (pending)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last EFF_D synchronised samples all
  // disagree with the accepted level. hist[f][k] is the raw level seen k+1 edges ago.
  bit              m_hist [FLOORS][16];
  logic [FLOORS-1:0] m_stable, m_press, m_pending, m_req;

  task automatic model_edge(input logic rst, input logic [FLOORS-1:0] btn,
                            input logic [2:0] pos, input logic door);
    logic [FLOORS-1:0] serve;
    logic [FLOORS-1:0] new_press;
    bit all_differ;
    if (rst) begin
      for (int f = 0; f < FLOORS; f++)
        for (int k = 0; k < 16; k++) m_hist[f][k] = 1'b0;
      m_stable = '0; m_press = '0; m_pending = '0; m_req = '0;
      return;
    end
    serve = '0;
    if (door && int'(pos) < FLOORS) serve[int'(pos)] = 1'b1;
    new_press = '0;
    for (int f = 0; f < FLOORS; f++) begin
      m_req[f] = m_press[f] && !m_pending[f] && !serve[f];
      m_pending[f] = serve[f] ? 1'b0 : (m_pending[f] | m_press[f]);
      all_differ = 1'b1;
      for (int j = 0; j < EFF_D; j++)
        if (m_hist[f][1+j] == m_stable[f]) all_differ = 1'b0;
      if (all_differ) begin
        m_stable[f] = ~m_stable[f];
        new_press[f] = m_stable[f];
      end
      for (int k = 15; k > 0; k--) m_hist[f][k] = m_hist[f][k-1];
      m_hist[f][0] = btn[f];
    end
    m_press = new_press;
  endtask

  // Scoreboard helpers
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock edge, advance the model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    model_edge(reset, btn_raw, floor_pos, door_open);
    #1;
    check_eq("model_floor_req", 32'(floor_req), 32'(m_req));
    check_eq("model_pending", 32'(pending), 32'(m_pending));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [FLOORS-1:0] acc;
  int pulses;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; btn_raw = '0; floor_pos = 3'd0; door_open = 1'b0;
    tick(); tick();
    check_eq("reset_req", 32'(floor_req), 32'h0);
    check_eq("reset_pend", 32'(pending), 32'h0);
    reset = 1'b0;

    // Clean press of floor 3
    btn_raw = 5'b01000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("clean_req", 32'(floor_req), (k == 2 + EFF_D) ? 32'h8 : 32'h0);
      check_eq("clean_pend", 32'(pending), (k >= 2 + EFF_D) ? 32'h8 : 32'h0);
    end
    btn_raw = '0;
    repeat (8) tick();

    // Bounce on floor 2
    do_reset();
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      btn_raw = (k % 2 == 0) ? 5'b00100 : 5'b00000;
      tick();
      acc |= floor_req;
    end
    btn_raw = '0;
    repeat (10) begin tick(); acc |= floor_req; end
`ifdef HALL_CALL_DEBOUNCE_EN
    check_eq("bounce_req", 32'(acc), 32'h0);
    check_eq("bounce_pend", 32'(pending), 32'h0);
`endif

    // Repeat presses of floor 1 without service
    do_reset();
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      btn_raw = 5'b00010;
      repeat (6) begin tick(); if (floor_req[1]) pulses++; end
      btn_raw = '0;
      repeat (6) begin tick(); if (floor_req[1]) pulses++; end
    end
    check_eq("spam_pulses", 32'(pulses), 32'd1);
    check_eq("spam_pend", 32'(pending[1]), 32'd1);

    // Service clears lamps one floor at a time
    do_reset();
    btn_raw = 5'b10010;
    repeat (8) tick();
    btn_raw = '0;
    repeat (8) tick();
    check_eq("svc_pend_before", 32'(pending), 32'h12);
    floor_pos = 3'd4; door_open = 1'b1;
    tick();
    check_eq("svc_pend_f4", 32'(pending), 32'h02);
    floor_pos = 3'd1;
    tick();
    check_eq("svc_pend_f1", 32'(pending), 32'h00);
    door_open = 1'b0; floor_pos = 3'd0;

    // Press at the open-door floor is absorbed; with the door shut it is accepted
    do_reset();
    floor_pos = 3'd2; door_open = 1'b1;
    acc = '0;
    btn_raw = 5'b00100;
    repeat (8) begin tick(); acc |= floor_req; end
    btn_raw = '0;
    repeat (8) begin tick(); acc |= floor_req; end
    check_eq("absorb_req", 32'(acc), 32'h0);
    check_eq("absorb_pend", 32'(pending), 32'h0);
    door_open = 1'b0;
    acc = '0;
    btn_raw = 5'b00100;
    repeat (8) begin tick(); acc |= floor_req; end
    btn_raw = '0;
    check_eq("closed_req", 32'(acc), 32'h4);
    check_eq("closed_pend", 32'(pending), 32'h4);
    floor_pos = 3'd0;

    // Reset in the middle of a floor-0 press
    do_reset();
    btn_raw = 5'b00001;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_req", 32'(floor_req), 32'h0);
    check_eq("midrst_pend", 32'(pending), 32'h0);
    reset = 1'b0;
    for (int j = 1; j <= EFF_D + 5; j++) begin
      tick();
      check_eq("midrst_lat", 32'(floor_req), (j == EFF_D + 3) ? 32'h1 : 32'h0);
    end
    check_eq("midrst_pend_after", 32'(pending), 32'h1);
    btn_raw = '0;

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int f = 0; f < FLOORS; f++)
        if ($urandom_range(0, 5) == 0) btn_raw[f] = ~btn_raw[f];
      if ($urandom_range(0, 3) == 0) floor_pos = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) door_open = ~door_open;
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
